// File: rtl/spi_slave_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_slave_responder_pkg: shared constants and helpers for the SPI slave.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package spi_slave_responder_pkg;

    localparam logic [0:0] ST_IDLE           = 1'b0;
    localparam logic [0:0] ST_ACTIVE         = 1'b1;
    localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;
    localparam int         BIT_CNT_W         = 3;

    // The TX shifter always emits bit 7 first, so LSB-first bytes are mirrored at load.
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_responder_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_edge_sync: multi-flop synchronizer with rise/fall detection.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_edge_sync
    import spi_slave_responder_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   dly_q;
    logic                   dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_slave_responder: oversampled SPI slave, all CPOL/CPHA modes, 8-bit.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = DEFAULT_FILL_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCK,
    input  logic       SS,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_oe,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic       LSBFE,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       underrun,
    output logic       abort,
    output logic       busy
);

    logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk (clk), .rst (rst), .d (SCK), .rise (w_sck_rise), .fall (w_sck_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk (clk), .rst (rst), .d (SS), .rise (w_ss_rise), .fall (w_ss_fall)
    );

    // MOSI shares the SCK pipeline depth so data and clock stay aligned.
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   w_mosi;

    logic [0:0]           state_q, state_d;
    logic                 cpol_q, cpol_d, cpha_q, cpha_d, lsbfe_q, lsbfe_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d, cnt_after;
    logic [7:0]           tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_next;
    logic [7:0]           buf_q, buf_d, rx_data_q, rx_data_d;
    logic                 buf_full_q, buf_full_d;
    logic                 miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic                 rx_valid_q, rx_valid_d, underrun_q, underrun_d, abort_q, abort_d;
    logic                 w_lead, w_trail, w_sample, w_shift;
    logic                 do_load, load_cpha, load_lsb;
    logic [7:0]           load_raw, load_o;

    assign w_mosi  = mosi_sync_q[SYNC_STAGES-1];
    assign w_lead  = cpol_q ? w_sck_fall : w_sck_rise;
    assign w_trail = cpol_q ? w_sck_rise : w_sck_fall;
    assign w_sample = cpha_q ? w_trail : w_lead;
    assign w_shift  = cpha_q ? w_lead  : w_trail;

    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        lsbfe_d     = lsbfe_q;
        cnt_d       = cnt_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        rx_data_d   = rx_data_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        do_load     = 1'b0;
        load_cpha   = cpha_q;
        load_lsb    = lsbfe_q;
        rx_next     = lsbfe_q ? {w_mosi, rx_sr_q[7:1]} : {rx_sr_q[6:0], w_mosi};
        cnt_after   = w_sample ? cnt_q + 3'd1 : cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    state_d   = ST_ACTIVE;
                    cpol_d    = CPOL;
                    cpha_d    = CPHA;
                    lsbfe_d   = LSBFE;
                    cnt_d     = '0;
                    rx_sr_d   = '0;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b1;
                    do_load   = 1'b1;
                    load_cpha = CPHA;
                    load_lsb  = LSBFE;
                end
            end
            default: begin
                // With CPHA=0 the trailing edge after the last sample must not eat the reloaded bit.
                if (w_shift && (cpha_q || cnt_q != '0)) begin
                    miso_d  = tx_sr_q[7];
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                end
                if (w_sample) begin
                    rx_sr_d = rx_next;
                    cnt_d   = cnt_after;
                    if (cnt_q == 3'd7) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        do_load    = ~w_ss_rise;
                    end
                end
                if (w_ss_rise) begin
                    state_d   = ST_IDLE;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    cnt_d     = '0;
                    rx_sr_d   = '0;
                    abort_d   = (cnt_after != '0);
                end
            end
        endcase

        load_raw = buf_full_q ? buf_q : FILL_BYTE;
        load_o   = load_lsb ? bit_rev8(load_raw) : load_raw;
        if (do_load) begin
            underrun_d = ~buf_full_q;
            buf_full_d = 1'b0;
            if (load_cpha) begin
                tx_sr_d = load_o;
            end else begin
                miso_d  = load_o[7];
                tx_sr_d = {load_o[6:0], 1'b0};
            end
        end

        // A write racing a load from an empty buffer lands in the buffer, not the frame.
        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsbfe_q     <= 1'b0;
            cnt_q       <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            lsbfe_q     <= lsbfe_d;
            cnt_q       <= cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            rx_data_q   <= rx_data_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign MISO     = miso_q;
    assign MISO_oe  = miso_oe_q;
    assign tx_ready = ~buf_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign underrun = underrun_q;
    assign abort    = abort_q;
    assign busy     = (state_q == ST_ACTIVE);

endmodule
`default_nettype wire
